// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory stage of a simple in-order pipeline. It holds a 64 x 32-bit data
// memory and stalls the upstream pipeline for WAIT_CYCLES cycles on every load
// or store. The access completes in the first cycle where freeze is low. At the
// edge that ends that cycle, any store is written and the WB pipeline register
// captures the instruction's results.
//
// Parameters
//   WAIT_CYCLES    stall cycles per memory access (0..15)
//
// Configuration macro
//   MEM_STAGE_CLR_EN   when defined, reset also clears every memory word to 0.
//                      When undefined, memory contents are not reset.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous, active-low reset
//   WB_en_in         in   write-back enable from the EXE register
//   MEM_R_EN_in      in   load request
//   MEM_W_EN_in      in   store request
//   ALU_result_in    in   byte address for loads/stores, or pass-through value
//   ST_val_in        in   store data
//   Dest_in          in   destination register index
//   WB_en            out  registered write-back enable (0 while stalled)
//   MEM_R_EN         out  registered load flag (0 while stalled)
//   ALU_result       out  registered pass-through result
//   Mem_read_value   out  registered load data
//   Dest             out  registered destination index
//   freeze           out  combinational stall to upstream registers and the PC
//   dbg_busy         out  1 while the access FSM is in BUSY
//   dbg_cnt          out  current wait down-counter value
//
// Handshake: freeze is the only flow control. While freeze is high, upstream
// holds every *_in input stable and this stage pushes bubbles downstream. A
// low freeze means the instruction on the inputs is consumed at the next
// rising edge.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_en_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] ST_val_in,
    input  logic [3:0]  Dest_in,
    output logic        WB_en,
    output logic        MEM_R_EN,
    output logic [31:0] ALU_result,
    output logic [31:0] Mem_read_value,
    output logic [3:0]  Dest,
    output logic        freeze,
    output logic        dbg_busy,
    output logic [3:0]  dbg_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam bit        HAS_WAIT = (WAIT_CYCLES != 0);
    // The counter loads WAIT_CYCLES-1. IDLE already spends one stalled cycle,
    // so BUSY covers the remaining stall cycles plus the completion cycle.
    localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // FSM and output-register state
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] mem_read_value_q, mem_read_value_d;
    logic [3:0]  dest_q, dest_d;

    // Data memory
    logic [31:0] mem_q [64];

    logic        req;
    logic        stall;
    logic        mem_we;
    logic [5:0]  mem_idx;
    logic [31:0] rd_data;

    // The memory starts at byte address 1024 (0x400). Subtracting 0x400 only
    // changes bits 10 and up, so bits [7:2] of the offset are the same as
    // bits [7:2] of the raw address. The index therefore comes straight from
    // the address, and the 64-word wrap falls out of the 6-bit index.
    assign mem_idx = ALU_result_in[7:2];
    assign rd_data = mem_q[mem_idx];
    assign req     = MEM_R_EN_in | MEM_W_EN_in;

    // Next-state, stall and output-register logic
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stall            = 1'b0;
        wb_en_d          = wb_en_q;
        mem_r_en_d       = mem_r_en_q;
        alu_result_d     = alu_result_q;
        mem_read_value_d = mem_read_value_q;
        dest_d           = dest_q;

        case (state_q)
            S_IDLE: begin
                if (req && HAS_WAIT) begin
                    stall   = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Completion cycle: stall is released this cycle.
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (stall) begin
            // Bubble: no write-back, no load. Data fields keep their values.
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
        end else begin
            wb_en_d          = WB_en_in;
            mem_r_en_d       = MEM_R_EN_in;
            alu_result_d     = ALU_result_in;
            // Read before the write on the same edge, so a combined
            // load+store returns the old contents.
            mem_read_value_d = rd_data;
            dest_d           = Dest_in;
        end
    end

    // Gating with rst keeps a store from landing while reset is held, which
    // matters when WAIT_CYCLES=0 and IDLE never stalls.
    assign mem_we = ~stall & MEM_W_EN_in & rst;

    // While reset is low the FSM is IDLE, but a request on the inputs would
    // still drive stall high. Mask it so upstream is never frozen in reset.
    assign freeze = stall & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            wb_en_q          <= 1'b0;
            mem_r_en_q       <= 1'b0;
            alu_result_q     <= 32'd0;
            mem_read_value_q <= 32'd0;
            dest_q           <= 4'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            wb_en_q          <= wb_en_d;
            mem_r_en_q       <= mem_r_en_d;
            alu_result_q     <= alu_result_d;
            mem_read_value_q <= mem_read_value_d;
            dest_q           <= dest_d;
        end
    end

`ifdef MEM_STAGE_CLR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= ST_val_in;
        end
    end
`else
    // No reset: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= ST_val_in;
        end
    end
`endif

    assign WB_en          = wb_en_q;
    assign MEM_R_EN       = mem_r_en_q;
    assign ALU_result     = alu_result_q;
    assign Mem_read_value = mem_read_value_q;
    assign Dest           = dest_q;
    assign dbg_busy       = (state_q == S_BUSY);
    assign dbg_cnt        = cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Drives mem_stage with WAIT_CYCLES=2 from a table of instructions. Expected
// outputs are queued when an instruction is driven and compared when it
// completes. Hand-written sequences cover these cases:
//   - reset behaviour, including an abort of a store while BUSY
//   - a second instance with WAIT_CYCLES=0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int WAIT = 2;
    localparam int W    = 70;   // {wb, mr, alu[31:0], rd[31:0], dest[3:0]}
`ifdef MEM_STAGE_CLR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT (WAIT_CYCLES=2) ----------------
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, st_val_in;
    logic [3:0]  dest_in;
    logic        wb_en, mem_r_en, freeze, dbg_busy;
    logic [31:0] alu_result, mem_read_value;
    logic [3:0]  dest, dbg_cnt;

    mem_stage #(.WAIT_CYCLES(WAIT)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .WB_en_in       (wb_en_in),
        .MEM_R_EN_in    (mem_r_en_in),
        .MEM_W_EN_in    (mem_w_en_in),
        .ALU_result_in  (alu_result_in),
        .ST_val_in      (st_val_in),
        .Dest_in        (dest_in),
        .WB_en          (wb_en),
        .MEM_R_EN       (mem_r_en),
        .ALU_result     (alu_result),
        .Mem_read_value (mem_read_value),
        .Dest           (dest),
        .freeze         (freeze),
        .dbg_busy       (dbg_busy),
        .dbg_cnt        (dbg_cnt)
    );

    // ---------------- DUT (WAIT_CYCLES=0) ----------------
    logic        z_wb_en_in, z_mem_r_en_in, z_mem_w_en_in;
    logic [31:0] z_alu_result_in, z_st_val_in;
    logic [3:0]  z_dest_in;
    logic        z_wb_en, z_mem_r_en, z_freeze, z_dbg_busy;
    logic [31:0] z_alu_result, z_mem_read_value;
    logic [3:0]  z_dest, z_dbg_cnt;

    mem_stage #(.WAIT_CYCLES(0)) dut_z (
        .clk            (clk),
        .rst            (rst_n),
        .WB_en_in       (z_wb_en_in),
        .MEM_R_EN_in    (z_mem_r_en_in),
        .MEM_W_EN_in    (z_mem_w_en_in),
        .ALU_result_in  (z_alu_result_in),
        .ST_val_in      (z_st_val_in),
        .Dest_in        (z_dest_in),
        .WB_en          (z_wb_en),
        .MEM_R_EN       (z_mem_r_en),
        .ALU_result     (z_alu_result),
        .Mem_read_value (z_mem_read_value),
        .Dest           (z_dest),
        .freeze         (z_freeze),
        .dbg_busy       (z_dbg_busy),
        .dbg_cnt        (z_dbg_cnt)
    );

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic        wb;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] st;
        logic [3:0]  dest;
        logic        chk_rd;   // compare Mem_read_value only for loads
        logic [31:0] exp_rd;
    } vec_t;

    vec_t       vecs [13];
    logic [W-1:0] exp_q [$];
    bit           chk_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic vec_t mk(input logic wb, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] st,
                                input logic [3:0] dest, input logic chk_rd,
                                input logic [31:0] exp_rd);
        vec_t v;
        v.wb = wb; v.rd = rd; v.wr = wr; v.addr = addr; v.st = st;
        v.dest = dest; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_en_in      = v.wb;
        mem_r_en_in   = v.rd;
        mem_w_en_in   = v.wr;
        alu_result_in = v.addr;
        st_val_in     = v.st;
        dest_in       = v.dest;
    endtask

    // Called at posedge+1. Drives one instruction and follows it to completion.
    // Checks the freeze length, the bubbles during the stall, and the
    // registered outputs after the completion edge.
    task automatic run_vec(input vec_t v, input string name);
        int           fz;
        bit           done;
        bit           f;
        logic [67:0]  held;
        logic [W-1:0] exp;
        logic [W-1:0] got;
        bit           chk;
        drive(v);
        exp_q.push_back({v.wb, v.rd, v.addr, v.exp_rd, v.dest});
        chk_q.push_back(v.chk_rd);
        fz   = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            f    = freeze;
            held = {alu_result, mem_read_value, dest};
            if (f) fz++;
            else   done = 1'b1;
            @(posedge clk);
            #1;
            if (f) check({name, "_bubble"},
                         {wb_en, mem_r_en, alu_result, mem_read_value, dest},
                         {2'b00, held});
        end
        check({name, "_done"}, W'(done), W'(1));
        check({name, "_freeze_cycles"}, W'(fz),
              W'(((v.rd | v.wr) ? WAIT : 0)));
        exp = exp_q.pop_front();
        chk = chk_q.pop_front();
        got = {wb_en, mem_r_en, alu_result,
               (chk ? mem_read_value : exp[35:4]), dest};
        check({name, "_out"}, got, exp);
    endtask

    initial begin
        // Table: wb rd wr addr st dest chk_rd exp_rd
        vecs[0]  = mk(0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd3,  0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 32'd1028, 32'h0,        4'd7,  1, 32'hDEADBEEF);
        vecs[2]  = mk(1, 0, 0, 32'h12,   32'h0,        4'd5,  0, 32'h0);
        vecs[3]  = mk(0, 0, 1, 32'd1280, 32'h0BADF00D, 4'd1,  0, 32'h0);
        vecs[4]  = mk(1, 1, 0, 32'd1024, 32'h0,        4'd2,  1, 32'h0BADF00D);
        vecs[5]  = mk(0, 0, 1, 32'd1279, 32'h11112222, 4'd8,  0, 32'h0);
        vecs[6]  = mk(1, 1, 0, 32'd1276, 32'h0,        4'd9,  1, 32'h11112222);
        vecs[7]  = mk(1, 1, 1, 32'd1028, 32'hCAFE0001, 4'd10, 1, 32'hDEADBEEF);
        vecs[8]  = mk(1, 1, 0, 32'd1028, 32'h0,        4'd11, 1, 32'hCAFE0001);
        vecs[9]  = mk(1, 1, 0, 32'd1284, 32'h0,        4'd12, 1, 32'hCAFE0001);
        vecs[10] = mk(1, 1, 0, 32'd1020, 32'h0,        4'd13, 1, 32'h11112222);
        vecs[11] = mk(0, 0, 1, 32'd1032, 32'h55AA55AA, 4'd14, 0, 32'h0);
        vecs[12] = mk(0, 0, 0, 32'hFFFF_FFFF, 32'h0,   4'd15, 0, 32'h0);

        // Reset with a store request present: outputs zero, freeze held low.
        rst_n = 1'b0;
        drive(mk(1, 0, 1, 32'd1036, 32'h77777777, 4'd6, 0, 32'h0));
        z_wb_en_in = 0; z_mem_r_en_in = 0; z_mem_w_en_in = 0;
        z_alu_result_in = 0; z_st_val_in = 0; z_dest_in = 0;
        #12;
        check("reset_outputs",
              {wb_en, mem_r_en, alu_result, mem_read_value, dest}, '0);
        check("reset_freeze", W'({freeze, dbg_busy}), W'(0));
        drive(mk(0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 32'h0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back table vectors, with no idle cycle between them.
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort a store to 1032 while BUSY.
        drive(mk(1, 0, 1, 32'd1032, 32'h99999999, 4'd9, 0, 32'h0));
        @(negedge clk);
        check("abort_freeze_idle", W'(freeze), W'(1));
        @(posedge clk);
        #1;
        check("abort_busy", W'({dbg_busy, dbg_cnt}), W'({1'b1, 4'd1}));
        #2 rst_n = 1'b0;
        drive(mk(1, 1, 0, 32'd1032, 32'h0, 4'd4, 0, 32'h0));
        #1;
        check("abort_outputs",
              {wb_en, mem_r_en, alu_result, mem_read_value, dest}, '0);
        check("abort_freeze", W'({freeze, dbg_busy}), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        // A request still present after release restarts the full wait.
        run_vec(mk(1, 1, 0, 32'd1032, 32'h0, 4'd4, 1,
                   (CLR ? 32'h0 : 32'h55AA55AA)), "post_abort_load");
        run_vec(mk(1, 1, 0, 32'd1028, 32'h0, 4'd3, 1,
                   (CLR ? 32'h0 : 32'hCAFE0001)), "post_reset_load");

        // WAIT_CYCLES=0 instance: store then load, one cycle each.
        drive(mk(0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 32'h0));
        z_wb_en_in = 0; z_mem_r_en_in = 0; z_mem_w_en_in = 1;
        z_alu_result_in = 32'd1100; z_st_val_in = 32'h13572468; z_dest_in = 4'd2;
        @(negedge clk);
        check("z_store_freeze", W'(z_freeze), W'(0));
        @(posedge clk);
        #1;
        check("z_store_out", W'({z_wb_en, z_mem_r_en, z_alu_result, z_dest}),
              W'({1'b0, 1'b0, 32'd1100, 4'd2}));
        z_wb_en_in = 1; z_mem_r_en_in = 1; z_mem_w_en_in = 0;
        z_st_val_in = 32'h0; z_dest_in = 4'd6;
        @(negedge clk);
        check("z_load_freeze", W'(z_freeze), W'(0));
        @(posedge clk);
        #1;
        check("z_load_out",
              {z_wb_en, z_mem_r_en, z_alu_result, z_mem_read_value, z_dest},
              {1'b1, 1'b1, 32'd1100, 32'h13572468, 4'd6});
        z_wb_en_in = 0; z_mem_r_en_in = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
